// File: rtl/fpmul_job_queue.sv
// Bus front end for the FP multiplier: staged operands feed a job FIFO, an issue FSM runs
// one job at a time on the core, and products with their flags land in a result FIFO.
module fpmul_job_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       A,
  input  logic             WE,
  input  logic [31:0]      InData,
  output logic [31:0]      OutData,
  output logic             irq,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_p,
  input  logic [5:0]       core_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

  logic [2*WIDTH-1:0] job_mem_q [DEPTH];
  logic [WIDTH+5:0]   res_mem_q [DEPTH];

  logic [AW-1:0]    job_rd_q, job_rd_d, job_wr_q, job_wr_d;
  logic [AW-1:0]    res_rd_q, res_rd_d, res_wr_q, res_wr_d;
  logic [CW-1:0]    job_cnt_q, job_cnt_d, res_cnt_q, res_cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic             irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             irq_q, irq_d, start_q, start_d;
  state_t           state_q, state_d;

  logic ctrl_wr, clr, push, pop, push_ok, pop_ok, job_pop, res_push;
  logic job_full, job_empty, res_full, res_empty, busy;
  logic [WIDTH-1:0] res_head_p;
  logic [5:0]       res_head_flags;

  always_comb begin
    ctrl_wr   = WE && (A == 2'd2);
    clr       = ctrl_wr && InData[31];
    push      = ctrl_wr && InData[16] && !clr;
    pop       = ctrl_wr && InData[17] && !clr;
    job_full  = (job_cnt_q == FULL);
    job_empty = (job_cnt_q == '0);
    res_full  = (res_cnt_q == FULL);
    res_empty = (res_cnt_q == '0);
    busy      = (state_q != S_IDLE);

    // A completion frees a job slot and fills a result slot on the same edge, so a
    // coincident push into a full queue or pop from an empty one still succeeds.
    job_pop  = (state_q == S_WAIT) && core_done && !clr;
    res_push = job_pop;
    push_ok  = push && (!job_full || job_pop);
    pop_ok   = pop && (!res_empty || res_push);

    opa_d    = (WE && (A == 2'd0)) ? InData : opa_q;
    opb_d    = (WE && (A == 2'd1)) ? InData : opb_q;
    irq_en_d = ctrl_wr ? InData[0] : irq_en_q;
    ovf_d    = !clr && (ovf_q || (push && !push_ok));
    unf_d    = !clr && (unf_q || (pop && !pop_ok));

    job_wr_d  = clr ? '0 : job_wr_q + AW'(push_ok);
    job_rd_d  = clr ? '0 : job_rd_q + AW'(job_pop);
    job_cnt_d = clr ? '0 : job_cnt_q + CW'(push_ok) - CW'(job_pop);
    res_wr_d  = clr ? '0 : res_wr_q + AW'(res_push);
    res_rd_d  = clr ? '0 : res_rd_q + AW'(pop_ok);
    res_cnt_d = clr ? '0 : res_cnt_q + CW'(res_push) - CW'(pop_ok);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!job_empty && !res_full && !clr) state_d = S_START;
      S_START: state_d = clr ? S_DRAIN : S_WAIT;
      S_WAIT:  begin
        if (core_done)  state_d = S_IDLE;
        else if (clr)   state_d = S_DRAIN;
      end
      S_DRAIN: if (core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    irq_d   = irq_en_d && (res_cnt_d != '0);

    res_head_p     = res_empty ? '0 : res_mem_q[res_rd_q][WIDTH+5:6];
    res_head_flags = res_empty ? '0 : res_mem_q[res_rd_q][5:0];
    core_a         = job_empty ? '0 : job_mem_q[job_rd_q][2*WIDTH-1:WIDTH];
    core_b         = job_empty ? '0 : job_mem_q[job_rd_q][WIDTH-1:0];

    OutData = '0;
    case (A)
      2'd0: OutData = opa_q;
      2'd1: OutData = opb_q;
      2'd2: OutData = {8'(res_cnt_q), 8'(job_cnt_q), 2'b00, res_head_flags, 1'b0,
                       unf_q, ovf_q, busy, job_empty, job_full, !res_empty, irq_en_q};
      default: OutData = res_head_p;
    endcase
  end

  assign core_start = start_q;
  assign irq        = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      job_rd_q  <= '0;
      job_wr_q  <= '0;
      job_cnt_q <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      irq_q     <= 1'b0;
      start_q   <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      job_rd_q  <= job_rd_d;
      job_wr_q  <= job_wr_d;
      job_cnt_q <= job_cnt_d;
      res_rd_q  <= res_rd_d;
      res_wr_q  <= res_wr_d;
      res_cnt_q <= res_cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      irq_q     <= irq_d;
      start_q   <= start_d;
      state_q   <= state_d;
    end
  end

  // Storage needs no reset: entries are only visible through the counts.
  always_ff @(posedge clk) begin
    if (push_ok)  job_mem_q[job_wr_q] <= {opa_q, opb_q};
    if (res_push) res_mem_q[res_wr_q] <= {core_p, core_flags};
  end
endmodule

// File: tb/tb_fpmul_job_queue.sv
// Self-checking bench for fpmul_job_queue: a behavioural multiplier core answers
// core_start, and FIFO queues in the bench predict every product, flag and count.
module tb_fpmul_job_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] PUSH = 32'h0001_0000;
  localparam logic [31:0] POP  = 32'h0002_0000;
  localparam logic [31:0] CLR  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, WE, irq, core_start, core_done;
  logic [1:0]  A;
  logic [31:0] InData, OutData, core_a, core_b, core_p;
  logic [5:0]  core_flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic core_hold;
  int   core_lat;
  bit   core_rand_lat;

  fpmul_job_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .InData(InData), .OutData(OutData),
    .irq(irq), .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_p(core_p), .core_flags(core_flags)
  );

  always #5 clk = ~clk;

  // Stand-in arithmetic for the core: 2.0 * 3.0 is exact, everything else is a
  // distinctive scramble so FIFO ordering errors show up.
  function automatic logic [37:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) p = 32'h40C0_0000;
    else p = (a ^ {b[15:0], b[31:16]}) + 32'h0123_4567;
    return {p, a[5:0] ^ b[5:0]};
  endfunction

  // Core model: reacts to core_start just after the edge, answers after a latency,
  // and holds the answer back while core_hold is set.
  initial begin
    logic [31:0] ma, mb;
    int lat;
    core_done = 1'b0; core_p = '0; core_flags = '0;
    forever begin
      @(posedge clk); #1;
      if (core_start) begin
        ma = core_a; mb = core_b;
        lat = core_rand_lat ? int'($urandom_range(1, 6)) : core_lat;
        repeat (lat) @(posedge clk);
        #1;
        while (core_hold) begin @(posedge clk); #1; end
        {core_p, core_flags} = core_fn(ma, mb);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); A = a; WE = 1'b1; InData = d;
    @(negedge clk); WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    A = a; WE = 1'b0; #1; d = OutData;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (core_done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_checks++;
    if (core_done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL %s_done_timeout core_done=%b after %0d cycles, required 1", tag, core_done, t);
    end
  endtask

  task automatic wait_res_count(input int n, input string tag);
    int t = 0;
    A = 2'd2; WE = 1'b0; #1;
    while (OutData[31:24] != n[7:0] && t < 400) begin @(negedge clk); #1; t++; end
    n_checks++;
    if (OutData[31:24] != n[7:0]) begin
      n_fail++; $display("[TB] FAIL %s_res_count got %0d, required %0d", tag, OutData[31:24], n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    rst = 1'b1; WE = 1'b0; A = '0; InData = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], d);
      e = (i == 2) ? 32'h8 : 32'h0;
      n_checks++;
      if (d !== e) begin n_fail++; $display("[TB] FAIL reset_addr%0d got %h, required %h", i, d, e); end
    end
    n_checks++;
    if ({core_start, irq, core_a, core_b} !== 66'd0) begin
      n_fail++; $display("[TB] FAIL reset_outputs start=%b irq=%b a=%h b=%h, required all 0", core_start, irq, core_a, core_b);
    end
  endtask

  task automatic test_single_job();
    logic [31:0] d;
    core_lat = 5;
    wr(2'd0, 32'h4000_0000);
    wr(2'd1, 32'h4040_0000);
    @(negedge clk); A = 2'd2; WE = 1'b1; InData = PUSH;
    @(negedge clk); WE = 1'b0; #1;
    n_checks++;
    if (core_start !== 1'b0 || OutData[23:16] !== 8'd1) begin
      n_fail++; $display("[TB] FAIL single_after_push start=%b jobs=%0d, required 0 and 1", core_start, OutData[23:16]);
    end
    @(negedge clk);
    n_checks++;
    if (core_start !== 1'b1 || core_a !== 32'h4000_0000 || core_b !== 32'h4040_0000) begin
      n_fail++; $display("[TB] FAIL single_start start=%b a=%h b=%h, required 1 40000000 40400000", core_start, core_a, core_b);
    end
    @(negedge clk);
    n_checks++;
    if (core_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_width start=%b, required 0", core_start); end
    wait_done("single");
    @(negedge clk);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h40C0_0000) begin n_fail++; $display("[TB] FAIL single_product got %h, required 40c00000", d); end
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h0100_000A) begin n_fail++; $display("[TB] FAIL single_status got %h, required 0100000a", d); end
    wr(2'd2, POP);
    rd(2'd2, d);
    n_checks++;
    if (d[31:24] !== 8'd0 || d[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_pop res_count=%0d, required 0", d[31:24]); end
  endtask

  task automatic test_overflow();
    logic [37:0] exp_q[$];
    logic [37:0] jobs[$];
    logic [31:0] a, b, d;
    logic exp_ovf = 1'b0;
    core_hold = 1'b0; core_lat = 2;
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom; b = $urandom;
      wr(2'd0, a); wr(2'd1, b); wr(2'd2, PUSH);
      exp_q.push_back(core_fn(a, b));
    end
    wait_res_count(DEPTH, "ovf_fill");
    core_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      wr(2'd0, a); wr(2'd1, b); wr(2'd2, PUSH);
      if (jobs.size() < DEPTH) jobs.push_back(core_fn(a, b));
      else exp_ovf = 1'b1;
    end
    rd(2'd2, d);
    n_checks++;
    if (d[23:16] !== 8'(jobs.size()) || d[5] !== exp_ovf || d[2] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_status jobs=%0d ovf=%b full=%b, required %0d %b 1", d[23:16], d[5], d[2], jobs.size(), exp_ovf);
    end
    while (exp_q.size() > 0) begin
      rd(2'd3, d);
      n_checks++;
      if (d !== exp_q[0][37:6]) begin n_fail++; $display("[TB] FAIL ovf_fifo_product got %h, required %h", d, exp_q[0][37:6]); end
      rd(2'd2, d);
      n_checks++;
      if (d[13:8] !== exp_q[0][5:0]) begin n_fail++; $display("[TB] FAIL ovf_fifo_flags got %h, required %h", d[13:8], exp_q[0][5:0]); end
      void'(exp_q.pop_front());
      wr(2'd2, POP);
    end
    wr(2'd2, POP);
    rd(2'd2, d);
    n_checks++;
    if (d[31:24] !== 8'd0 || d[6] !== 1'b1 || d[5] !== 1'b1 || d[23:16] !== 8'(DEPTH)) begin
      n_fail++; $display("[TB] FAIL underflow_status got %h, required res 0, jobs %0d, unf 1, ovf 1", d, DEPTH);
    end
    core_hold = 1'b0;
    wait_res_count(DEPTH, "ovf_drain");
    while (jobs.size() > 0) begin
      rd(2'd3, d);
      n_checks++;
      if (d !== jobs[0][37:6]) begin n_fail++; $display("[TB] FAIL ovf_second_product got %h, required %h", d, jobs[0][37:6]); end
      void'(jobs.pop_front());
      wr(2'd2, POP);
    end
    wr(2'd2, CLR);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("[TB] FAIL ovf_clear_status got %h, required 00000008", d); end
  endtask

  task automatic test_irq();
    wr(2'd0, 32'h3F80_0001); wr(2'd1, 32'h4000_0003);
    core_lat = 3;
    @(negedge clk); A = 2'd2; WE = 1'b1; InData = PUSH | 32'h1;
    @(negedge clk); WE = 1'b0;
    wait_done("irq");
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_before_done irq=%b, required 0", irq); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_after_done irq=%b, required 1", irq); end
    A = 2'd2; WE = 1'b1; InData = POP | 32'h1;
    @(negedge clk); WE = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_after_pop irq=%b, required 0", irq); end
    wr(2'd2, 32'h0);
  endtask

  task automatic test_clr_drain();
    logic [31:0] d;
    core_hold = 1'b1; core_lat = 1;
    wr(2'd2, PUSH);
    repeat (4) @(negedge clk);
    rd(2'd2, d);
    n_checks++;
    if (d[4] !== 1'b1 || d[23:16] !== 8'd1) begin n_fail++; $display("[TB] FAIL clr_pre busy=%b jobs=%0d, required 1 1", d[4], d[23:16]); end
    wr(2'd2, CLR);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h0000_0018) begin n_fail++; $display("[TB] FAIL clr_drain_status got %h, required 00000018", d); end
    core_hold = 1'b0;
    wait_done("drain");
    @(negedge clk);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("[TB] FAIL clr_after_drain got %h, required 00000008", d); end
  endtask

  task automatic test_simultaneous();
    logic [37:0] jobs[$];
    logic [31:0] a, b, d;
    core_hold = 1'b1; core_lat = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      a = $urandom; b = $urandom;
      wr(2'd0, a); wr(2'd1, b);
      if (i < DEPTH) wr(2'd2, PUSH);
      jobs.push_back(core_fn(a, b));
    end
    rd(2'd2, d);
    n_checks++;
    if (d[23:16] !== 8'(DEPTH) || d[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_fill jobs=%0d, required %0d", d[23:16], DEPTH); end
    @(negedge clk); core_hold = 1'b0;
    @(negedge clk); core_hold = 1'b1; A = 2'd2; WE = 1'b1; InData = PUSH;
    @(negedge clk); WE = 1'b0; #1;
    n_checks++;
    if (OutData[23:16] !== 8'(DEPTH) || OutData[31:24] !== 8'd1 || OutData[6:5] !== 2'b00) begin
      n_fail++; $display("[TB] FAIL simul_push status=%h, required jobs %0d res 1 no sticky", OutData, DEPTH);
    end
    rd(2'd3, d);
    n_checks++;
    if (d !== jobs[0][37:6]) begin n_fail++; $display("[TB] FAIL simul_product got %h, required %h", d, jobs[0][37:6]); end
    wr(2'd2, POP);
    repeat (3) @(negedge clk);
    core_hold = 1'b0;
    @(negedge clk); core_hold = 1'b1; A = 2'd2; WE = 1'b1; InData = POP;
    @(negedge clk); WE = 1'b0; #1;
    n_checks++;
    if (OutData[31:24] !== 8'd0 || OutData[23:16] !== 8'(DEPTH - 1) || OutData[6:5] !== 2'b00) begin
      n_fail++; $display("[TB] FAIL simul_pop status=%h, required res 0 jobs %0d no sticky", OutData, DEPTH - 1);
    end
    wr(2'd2, CLR);
    core_hold = 1'b0;
    wait_done("simul_drain");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [37:0] exp_q[$];
    logic [31:0] a, b, d;
    int n;
    core_hold = 1'b0; core_rand_lat = 1'b1;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        a = $urandom; b = $urandom;
        wr(2'd0, a); wr(2'd1, b); wr(2'd2, PUSH);
        exp_q.push_back(core_fn(a, b));
      end
      wait_res_count(n, "random");
      rd(2'd2, d);
      n_checks++;
      if (d[23:16] !== 8'd0 || d[4] !== 1'b0) begin n_fail++; $display("[TB] FAIL random_idle jobs=%0d busy=%b, required 0 0", d[23:16], d[4]); end
      while (exp_q.size() > 0) begin
        rd(2'd3, d);
        n_checks++;
        if (d !== exp_q[0][37:6]) begin n_fail++; $display("[TB] FAIL random_product got %h, required %h", d, exp_q[0][37:6]); end
        rd(2'd2, d);
        n_checks++;
        if (d[13:8] !== exp_q[0][5:0]) begin n_fail++; $display("[TB] FAIL random_flags got %h, required %h", d[13:8], exp_q[0][5:0]); end
        void'(exp_q.pop_front());
        wr(2'd2, POP);
      end
    end
    core_rand_lat = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    core_hold = 1'b1; core_lat = 1;
    wr(2'd0, 32'h1234_5678); wr(2'd2, PUSH);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h8 || core_start !== 1'b0 || core_a !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midreset_status got %h start=%b a=%h, required 00000008 0 0", d, core_start, core_a);
    end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_opa got %h, required 0", d); end
    core_hold = 1'b0;
    repeat (10) @(negedge clk);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("[TB] FAIL stray_done_status got %h, required 00000008", d); end
  endtask

  initial begin
    core_hold = 1'b0; core_lat = 5; core_rand_lat = 1'b0;
    rst = 1'b1; WE = 1'b0; A = '0; InData = '0;
    test_reset();
    test_single_job();
    test_overflow();
    test_irq();
    test_clr_drain();
    test_simultaneous();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
